// File: rtl/lift_call_scheduler_if.sv
// Call-scheduler <-> lift-controller bundle: buttons and current floor in, target floor and status out.
// master = scheduler side, slave = controller/button side.
interface lift_call_scheduler_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic [NUM_FLOORS-1:0] btn;
  logic [FLOOR_W-1:0]    lift_state;
  logic [FLOOR_W-1:0]    floor;
  logic                  req_valid;
  logic                  arrived;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  wdog_err;

  modport master (
    input  btn, lift_state,
    output floor, req_valid, arrived, pending, dir_up, wdog_err
  );

  modport slave (
    output btn, lift_state,
    input  floor, req_valid, arrived, pending, dir_up, wdog_err
  );
endinterface

// File: rtl/lift_call_scheduler.sv
// Latches floor calls and issues targets in SCAN order; button edge to req_valid takes 3 edges, no backpressure.
// Optional arrival watchdog: define LIFT_SCHED_WDOG_EN.
module lift_call_scheduler #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int DWELL_CYCLES = 3,
  parameter int WDOG_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lift_call_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_ARRIVE, DWELL} state_t;

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  state_t                state;
  logic [FLOOR_W-1:0]    floor_q;
  logic [FLOOR_W-1:0]    target;
  logic                  req_valid_q;
  logic                  arrived_q;
  logic                  dir_up_q;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] pending_set;
  logic [NUM_FLOORS-1:0] floor_onehot;
  logic [DWELL_W-1:0]    dwell_cnt;
  logic                  at_target;

  logic                  ge_hit, le_hit;
  logic [FLOOR_W-1:0]    ge_idx, gt_idx, le_idx, lt_idx;
  logic [FLOOR_W-1:0]    sel_floor;
  logic                  sel_dir_up;

  assign pending_set  = pending_q | bus.btn;
  assign floor_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << floor_q;
  assign at_target    = (int'(bus.lift_state) < NUM_FLOORS) && (bus.lift_state == floor_q);

  // ge/gt scan downward so the lowest match wins; le/lt scan upward so the highest wins.
  always_comb begin
    ge_hit = 1'b0;
    le_hit = 1'b0;
    ge_idx = '0;
    gt_idx = '0;
    le_idx = '0;
    lt_idx = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && i >= int'(bus.lift_state)) begin
        ge_hit = 1'b1;
        ge_idx = FLOOR_W'(i);
      end
      if (pending_q[i] && i > int'(bus.lift_state)) gt_idx = FLOOR_W'(i);
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && i <= int'(bus.lift_state)) begin
        le_hit = 1'b1;
        le_idx = FLOOR_W'(i);
      end
      if (pending_q[i] && i < int'(bus.lift_state)) lt_idx = FLOOR_W'(i);
    end
    sel_dir_up = dir_up_q;
    sel_floor  = '0;
    if (dir_up_q) begin
      if (ge_hit) sel_floor = ge_idx;
      else begin
        sel_floor  = lt_idx;
        sel_dir_up = 1'b0;
      end
    end else begin
      if (le_hit) sel_floor = le_idx;
      else begin
        sel_floor  = gt_idx;
        sel_dir_up = 1'b1;
      end
    end
  end

`ifdef LIFT_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_err_q;
  assign bus.wdog_err = wdog_err_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      floor_q     <= '0;
      target      <= '0;
      req_valid_q <= 1'b0;
      arrived_q   <= 1'b0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      dwell_cnt   <= '0;
`ifdef LIFT_SCHED_WDOG_EN
      wdog_cnt    <= '0;
      wdog_err_q  <= 1'b0;
`endif
    end else begin
      arrived_q <= 1'b0;
      pending_q <= pending_set;
      case (state)
        IDLE: begin
          if (|pending_q) begin
            target   <= sel_floor;
            dir_up_q <= sel_dir_up;
            state    <= DISPATCH;
          end
        end
        DISPATCH: begin
          floor_q     <= target;
          req_valid_q <= 1'b1;
`ifdef LIFT_SCHED_WDOG_EN
          wdog_cnt    <= '0;
`endif
          state       <= WAIT_ARRIVE;
        end
        WAIT_ARRIVE: begin
          if (at_target) begin
            req_valid_q <= 1'b0;
            arrived_q   <= 1'b1;
            dwell_cnt   <= DWELL_W'(DWELL_CYCLES - 1);
            state       <= DWELL;
          end
`ifdef LIFT_SCHED_WDOG_EN
          else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            wdog_err_q  <= 1'b1;
            req_valid_q <= 1'b0;
            pending_q   <= pending_set & ~floor_onehot;
            state       <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        DWELL: begin
          // Clearing after the OR absorbs a same-edge press of the served floor.
          if (dwell_cnt == '0) begin
            pending_q <= pending_set & ~floor_onehot;
            state     <= IDLE;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.floor     = floor_q;
  assign bus.req_valid = req_valid_q;
  assign bus.arrived   = arrived_q;
  assign bus.pending   = pending_q;
  assign bus.dir_up    = dir_up_q;

endmodule
